// File: rtl/uart_pkg.sv
// Shared types and register layout for the memory-mapped UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam logic [31:0] RXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_NE      = 0;
  localparam int STAT_OVR     = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_IRQ_EN  = 3;
  localparam int STAT_CNT_LSB = 4;

  function automatic logic [3:0] sat_count(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO and RXDATA/STATUS bus registers.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h40000018,
  parameter int          CLK_DIV    = 162,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  rx_state_e        state_q, state_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic             rx_s, tick, push, ferr_set, ovr_set, pop;
  logic             hit_data, hit_stat;
  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      status_word;
  logic             unused_wdata;

  assign rx_s         = sync_q[1];
  assign tick         = (div_q == DIV_W'(CLK_DIV - 1));
  assign hit_data     = (addr == BASE_ADDR + RXDATA_OFS);
  assign hit_stat     = (addr == BASE_ADDR + STATUS_OFS);
  assign pop          = rd && hit_data && !fifo_empty;
  assign ovr_set      = push && fifo_full && !pop;
  assign irq          = irq_q;
  assign unused_wdata = ^{wdata[31:4], wdata[0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Receive FSM; IDLE re-arms only after seeing the line high, so a held break yields one frame.
  always_comb begin
    sync_d   = {sync_q[0], uart_rx};
    div_d    = tick ? '0 : div_q + 1'b1;
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    armed_d  = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        armed_d = rx_s;
        if (armed_q && !rx_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: if (tick) begin
        if (tcnt_q == 4'd7) begin
          tcnt_d  = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      ST_DATA: if (tick) begin
        if (tcnt_q == 4'd15) begin
          shift_d[idx_q] = rx_s;
          tcnt_d         = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      ST_STOP: if (tick) begin
        if (tcnt_q == 4'd15) begin
          push     = rx_s;
          ferr_set = !rx_s;
          state_d  = ST_IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a write-one-to-clear takes priority.
  always_comb begin
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    irq_en_d = irq_en_q;
    if (wr && hit_stat) begin
      irq_en_d = wdata[STAT_IRQ_EN];
      if (wdata[STAT_OVR])  ovr_d  = 1'b0;
      if (wdata[STAT_FERR]) ferr_d = 1'b0;
    end
    if (ovr_set)  ovr_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
    irq_d = irq_en_q && !fifo_empty;
  end

  always_comb begin
    status_word                         = '0;
    status_word[STAT_NE]                = !fifo_empty;
    status_word[STAT_OVR]               = ovr_q;
    status_word[STAT_FERR]              = ferr_q;
    status_word[STAT_IRQ_EN]            = irq_en_q;
    status_word[STAT_CNT_LSB +: 4]      = sat_count(32'(fifo_count));
    rdata = '0;
    if (rd && hit_data && !fifo_empty) rdata = {24'd0, fifo_head};
    else if (rd && hit_stat)           rdata = status_word;
  end

  // NOTE: every flop here updates with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b11;
      div_q    <= '0;
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      armed_q  <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      div_q    <= div_d;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: directed corner cases plus randomized traffic vs a queue model.
module tb_uart_rx_mmio;

  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int          BIT  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a byte queue plus flags, driven by whole-frame and whole-access events.
  logic [7:0] m_q[$];
  bit m_ovr, m_ferr, m_irq_en;

  function automatic void model_reset();
    m_q.delete(); m_ovr = 0; m_ferr = 0; m_irq_en = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) m_ferr = 1;
    else if (m_q.size() < 4) m_q.push_back(b);
    else m_ovr = 1;
  endfunction

  function automatic logic [31:0] model_read_data();
    if (m_q.size() == 0) return 32'd0;
    return {24'd0, m_q.pop_front()};
  endfunction

  function automatic logic [31:0] model_status();
    int n = m_q.size();
    return {24'd0, 4'((n > 15) ? 15 : n), m_irq_en, m_ferr, m_ovr, n > 0};
  endfunction

  function automatic void model_write_status(input logic [31:0] w);
    m_irq_en = w[3];
    if (w[1]) m_ovr = 0;
    if (w[2]) m_ferr = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    #1 d = rdata;
    @(posedge clk); #1 rd = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk); addr = a; wdata = w; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic hold_rx(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    hold_rx(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_rx(b[i], BIT);
    hold_rx(stop, BIT);
    hold_rx(1'b1, 16);
  endtask

  task automatic do_reset();
    reset = 1'b1; uart_rx = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          rise;
    bit          stop_ok;

    tbl[0] = '{0, STAT, 0, 32'h43, "ovr_status_full"};
    tbl[1] = '{0, BASE, 0, 32'h01, "ovr_read_01"};
    tbl[2] = '{0, BASE, 0, 32'h02, "ovr_read_02"};
    tbl[3] = '{0, STAT, 0, 32'h23, "ovr_status_two_left"};
    tbl[4] = '{0, BASE, 0, 32'h03, "ovr_read_03"};
    tbl[5] = '{0, BASE, 0, 32'h04, "ovr_read_04"};
    tbl[6] = '{0, BASE, 0, 32'h00, "read_when_empty"};
    tbl[7] = '{0, STAT, 0, 32'h02, "ovr_sticky_after_drain"};
    tbl[8] = '{1, STAT, 32'h2, 32'h0, "w1c_ovr"};
    tbl[9] = '{0, STAT, 0, 32'h00, "ovr_cleared"};

    do_reset();
    check("reset_rdata_idle", rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(STAT, d);
    check("reset_status", d, 32'd0);

    // Single byte round trip.
    send_frame(8'hA5, 1'b1);
    check("no_irq_when_disabled", {31'd0, irq}, 32'd0);
    bus_read(STAT, d);
    check("status_one_byte", d, 32'h11);
    bus_read(BASE, d);
    check("read_a5", d, 32'hA5);
    bus_read(STAT, d);
    check("status_after_pop", d, 32'd0);

    // Overflow: five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) bus_write(tbl[i].a, tbl[i].w);
      else begin
        bus_read(tbl[i].a, d);
        check(tbl[i].name, d, tbl[i].exp);
      end
    end

    // Framing error.
    send_frame(8'h3C, 1'b0);
    bus_read(STAT, d);
    check("ferr_set_no_push", d, 32'h04);
    bus_write(STAT, 32'h4);
    bus_read(STAT, d);
    check("ferr_cleared", d, 32'd0);

    // Short low glitch must not start a frame; the receiver must still accept the next one.
    hold_rx(1'b0, 8);
    hold_rx(1'b1, 3 * BIT);
    bus_read(STAT, d);
    check("glitch_no_effect", d, 32'd0);
    send_frame(8'h5A, 1'b1);
    bus_read(BASE, d);
    check("after_glitch_read_5a", d, 32'h5A);

    // Interrupt timing.
    bus_write(STAT, 32'h8);
    repeat (2) @(posedge clk);
    #1 check("irq_en_empty_no_irq", {31'd0, irq}, 32'd0);
    rise = -1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk); #1;
        for (int c = 0; c < 700; c++) begin
          @(posedge clk); #1;
          if (irq && rise < 0) rise = c;
        end
      end
    join
    check("irq_rise_near_push", {31'd0, (rise >= 600 && rise <= 620)}, 32'd1);
    bus_read(BASE, d);
    check("irq_read_55", d, 32'h55);
    check("irq_still_high_at_pop_edge", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_low_after_pop", {31'd0, irq}, 32'd0);

    // Reset in the middle of the data bits of 0x77.
    @(posedge clk); #1;
    hold_rx(1'b0, BIT);
    hold_rx(1'b1, 3 * BIT);
    hold_rx(1'b0, BIT / 2);
    do_reset();
    hold_rx(1'b1, 2 * BIT);
    send_frame(8'h12, 1'b1);
    bus_read(STAT, d);
    check("midframe_reset_status", d, 32'h11);
    bus_read(BASE, d);
    check("midframe_reset_read_12", d, 32'h12);
    bus_read(STAT, d);
    check("midframe_reset_drained", d, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          b = 8'($urandom);
          stop_ok = ($urandom_range(0, 7) != 0);
          send_frame(b, stop_ok);
          model_frame(b, stop_ok);
        end
        2: begin
          bus_read(BASE, d);
          check("rand_rxdata", d, model_read_data());
        end
        3: begin
          bus_read(STAT, d);
          check("rand_status", d, model_status());
        end
        4: begin
          d = $urandom;
          bus_write(STAT, d);
          model_write_status(d);
        end
        default: begin
          bus_write(BASE, $urandom);
          bus_read(BASE + 32'd8, d);
          check("rand_unmapped_read", d, 32'd0);
        end
      endcase
      repeat (2) @(posedge clk);
      #1 check("rand_irq", {31'd0, irq}, {31'd0, m_irq_en && (m_q.size() > 0)});
    end
    bus_read(STAT, d);
    check("rand_final_status", d, model_status());
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE, d);
      check("rand_drain", d, model_read_data());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
